multicycle_core: RTL and testbench
==================================

# multicycle_core

Parametrised multi-cycle successor to the single-cycle 16-bit core: same 16-bit instruction encoding, generalised in data width, PC width and register count, with load/store and HALT added. Instruction and data memories are external and reached through req/valid handshakes, so the core tolerates wait states. The FSM sequences each instruction through fetch, decode, execute and memory states. The block is the processor top inside the SoC wrapper, between the instruction ROM controller and the data RAM.

## Interface
- DATA_W, 16: register/ALU/data width (≥ 8)
- PC_W, 10: PC and instruction-address width
- NREGS, 8: register count (power of two, ≤ 8; field is 3 bits, upper indices alias modulo NREGS)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_valid  in  1  fetch data valid
- imem_rdata  in  16  instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_W  byte-free word address
- dmem_wdata  out  DATA_W  store data
- dmem_ready  in  1  access complete (load data valid)
- dmem_rdata  in  DATA_W  load data
- pc  out  PC_W  current PC
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  core in HALT state

## Operation
- Fields: op[15:13], rA[12:10], rB[9:7], rC[2:0], imm7[6:0] sign-extended to DATA_W (simm).
- 000 ADD: rA = rB + rC. 001 ADDI: rA = rB + simm. 010 SUBI: rA = rB − simm.
- 011 BEQ: if rA == rB, pc = pc + 1 + simm, else pc + 1.
- 100 JALR: rA = pc + 1 (zero-extended/truncated to DATA_W); pc = rB[PC_W-1:0]; imm7 ignored.
- 101 LW: rA = mem[rB + simm]. 110 SW: mem[rB + simm] = rA. 111 HALT.
- r0 reads zero; writes to r0 discarded.
- Arithmetic wraps modulo 2^DATA_W; PC arithmetic wraps modulo 2^PC_W.
- States: FETCH → DECODE → EXEC → (MEM for LW/SW) → FETCH; HALT terminal.
  - FETCH: imem_req=1, imem_addr=pc; on imem_valid latch IR, go DECODE.
  - DECODE: read rA, rB, rC into operand registers.
  - EXEC: ALU/compare; non-memory ops write rA, update pc, pulse retire, go FETCH. LW/SW: latch address, go MEM. HALT: go HALT, pulse retire, pc unchanged.
  - MEM: dmem_req=1, dmem_we = SW, address/wdata held stable; on dmem_ready, LW writes rA, pc += 1, retire, go FETCH.
- Reset (low): state FETCH, pc 0, all registers 0, IR 0; all outputs 0 while reset is low.

## Timing
- Requests are combinational from state; addr/wdata must remain stable while req is high until valid/ready is sampled.
- Same-cycle response allowed: zero-wait ALU instruction is 3 cycles; LW/SW is 4 cycles. Each wait cycle adds one.
- imem_req rises in the first cycle with reset high.
- retire is asserted in the cycle before the state returns to FETCH (or enters HALT); pc changes on the same edge.
- BEQ/JALR: the new pc is visible the cycle after EXEC; no delay slot, no prefetch.
- Reset mid-transaction drops req immediately and discards the pending response; a late valid/ready after reset is ignored unless in the matching state.
- In HALT, both req outputs are 0 and halted=1 until reset.

## Structure
- Package core_pkg: opcode localparams, field bit positions, state enum {FETCH, DECODE, EXEC, MEM, HALT}, simm sign-extension function.
- Sub-module core_regfile (params DATA_W, NREGS): two async reads plus one sync write, r0 hardwired zero, async active-low clear. FSM, ALU and PC logic stay in the top.

## Test plan
- Reset release, imem returns ADDI r1,r0,5 with zero wait → r1=5, pc=1 after 3 cycles, one retire pulse.
- ADD r3,r1,r2 with r1=0xFFFF, r2=2 (DATA_W=16) → r3=0x0001 wrap; ADDI r0,r0,7 → r0 stays 0.
- BEQ r1,r1,−2 at pc=4 → pc=3; BEQ unequal → pc=5; JALR r5,r2 with r2=0x20 at pc=7 → r5=8, pc=0x20.
- SW r1→[r2+3] with dmem_ready delayed 2 cycles → dmem_addr/wdata stable, req held 3 cycles; then LW r4 from the same address returns the value, r4 matches.
- imem_valid withheld 5 cycles → imem_req and imem_addr held constant, no retire; reset pulsed mid-wait → pc=0, req=0, registers cleared.
- HALT → halted=1, no further req over 20 cycles; repeat with DATA_W=32, NREGS=4 (r5 aliases r1).

Source files
------------

// File: rtl/core_pkg.sv
// Shared encoding constants, FSM state type and immediate helper for the
// multi-cycle core.
package core_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUBI = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_JALR = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RA_MSB  = 12;
  localparam int RA_LSB  = 10;
  localparam int RB_MSB  = 9;
  localparam int RB_LSB  = 7;
  localparam int RC_MSB  = 2;
  localparam int RC_LSB  = 0;
  localparam int IMM_MSB = 6;
  localparam int IMM_LSB = 0;

  // Widest operand the immediate is ever extended into; callers size-cast down.
  localparam int SIMM_W = 64;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;

  function automatic logic [SIMM_W-1:0] sext_imm7(input logic [6:0] imm);
    return {{(SIMM_W-7){imm[6]}}, imm};
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Instruction-fetch and data-memory handshake bundle between the core
// (master) and the memory controllers (slave).
interface multicycle_core_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 10
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_valid;
  logic [15:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ready;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_valid, imem_rdata, dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_valid, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/core_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// r0 reads as zero and 3-bit indices alias modulo NREGS.
module core_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        raddr0,
  input  logic [2:0]        raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  // Masking rather than slicing keeps every index bit live for any NREGS.
  localparam logic [2:0] IDX_MASK = 3'(NREGS - 1);

  logic [DATA_W-1:0] regs [1:NREGS-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 1; i < NREGS; i++)
        if ((waddr & IDX_MASK) == 3'(i)) regs[i] <= wdata;
    end
  end

  always_comb begin
    rdata0 = '0;
    rdata1 = '0;
    for (int i = 1; i < NREGS; i++) begin
      if ((raddr0 & IDX_MASK) == 3'(i)) rdata0 = regs[i];
      if ((raddr1 & IDX_MASK) == 3'(i)) rdata1 = regs[i];
    end
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle 16-bit-encoding processor core with handshaked instruction and
// data memories.
//   state  | meaning
//   FETCH  | imem_req high, wait for imem_valid, latch IR
//   DECODE | read operands into operand registers
//   EXEC   | ALU/branch; write back and retire, or latch address for MEM
//   MEM    | dmem_req high until dmem_ready; LW write-back, retire
//   HALT   | terminal, no requests until reset
module multicycle_core
  import core_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 10,
  parameter int NREGS  = 8
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_core_if.master   bus,
  output logic [PC_W-1:0]     pc,
  output logic                retire,
  output logic                halted
);

  state_t            state, state_nxt;
  logic [15:0]       ir;
  logic [DATA_W-1:0] opnd_b, opnd_x, mem_addr, mem_wdata;
  logic [2:0]        op, ra, rb, rc;
  logic [DATA_W-1:0] simm, alu_res, eff_addr, link;
  logic [PC_W-1:0]   simm_pc, pc_plus1, pc_exec, pc_nxt;
  logic [DATA_W-1:0] rf_rd0, rf_rd1, rf_wdata;
  logic              rf_we, fetch_req, mem_req, mem_we;
  logic              ir_load, opnd_load, mem_load, pc_load;

  assign op = ir[OP_MSB:OP_LSB];
  assign ra = ir[RA_MSB:RA_LSB];
  assign rb = ir[RB_MSB:RB_LSB];
  assign rc = ir[RC_MSB:RC_LSB];

  assign simm    = DATA_W'(sext_imm7(ir[IMM_MSB:IMM_LSB]));
  assign simm_pc = PC_W'(sext_imm7(ir[IMM_MSB:IMM_LSB]));

  core_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr0 (rb),
    .raddr1 ((op == OP_ADD) ? rc : ra),
    .rdata0 (rf_rd0),
    .rdata1 (rf_rd1),
    .we     (rf_we),
    .waddr  (ra),
    .wdata  (rf_wdata)
  );

  // opnd_b holds rB; opnd_x holds rC for ADD and rA for everything else.
  assign pc_plus1 = pc + PC_W'(1);
  assign link     = DATA_W'(pc_plus1);
  assign eff_addr = opnd_b + simm;

  always_comb begin
    alu_res = eff_addr;
    case (op)
      OP_ADD:  alu_res = opnd_b + opnd_x;
      OP_SUBI: alu_res = opnd_b - simm;
      OP_JALR: alu_res = link;
      default: alu_res = eff_addr;
    endcase
  end

  always_comb begin
    pc_exec = pc_plus1;
    if (op == OP_BEQ && opnd_x == opnd_b) pc_exec = pc_plus1 + simm_pc;
    else if (op == OP_JALR)               pc_exec = PC_W'(opnd_b);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fetch_req = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = alu_res;
    pc_load   = 1'b0;
    pc_nxt    = pc_plus1;
    ir_load   = 1'b0;
    opnd_load = 1'b0;
    mem_load  = 1'b0;
    case (state)
      FETCH: begin
        fetch_req = 1'b1;
        if (bus.imem_valid) begin
          ir_load   = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        opnd_load = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        if (op == OP_LW || op == OP_SW) begin
          mem_load  = 1'b1;
          state_nxt = MEM;
        end else if (op == OP_HALT) begin
          retire    = 1'b1;
          state_nxt = HALT;
        end else begin
          retire    = 1'b1;
          pc_load   = 1'b1;
          pc_nxt    = pc_exec;
          rf_we     = (op != OP_BEQ);
          state_nxt = FETCH;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_SW);
        if (bus.dmem_ready) begin
          retire    = 1'b1;
          pc_load   = 1'b1;
          rf_we     = (op == OP_LW);
          rf_wdata  = bus.dmem_rdata;
          state_nxt = FETCH;
        end
      end
      HALT: halted = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      ir        <= '0;
      opnd_b    <= '0;
      opnd_x    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (pc_load) pc <= pc_nxt;
      if (ir_load) ir <= bus.imem_rdata;
      if (opnd_load) begin
        opnd_b <= rf_rd0;
        opnd_x <= rf_rd1;
      end
      if (mem_load) begin
        mem_addr  <= eff_addr;
        mem_wdata <= opnd_x;
      end
    end
  end

  // State resets to FETCH, so the fetch request is masked while reset is held.
  assign bus.imem_req   = fetch_req & reset;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = mem_req;
  assign bus.dmem_we    = mem_we;
  assign bus.dmem_addr  = mem_addr;
  assign bus.dmem_wdata = mem_wdata;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench: ALU vector table plus hand sequences for fetch timing,
// branches, memory wait states, reset mid-fetch, HALT and a 32-bit/4-reg build.
module tb_multicycle_core;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_core_if #(.DATA_W(16), .PC_W(10)) bus16 ();
  multicycle_core_if #(.DATA_W(32), .PC_W(10)) bus32 ();

  logic [9:0] pc16, pc32;
  logic       retire16, retire32, halted16, halted32;

  multicycle_core #(.DATA_W(16), .PC_W(10), .NREGS(8)) u_dut16 (
    .clk(clk), .reset(reset), .bus(bus16.master),
    .pc(pc16), .retire(retire16), .halted(halted16));

  multicycle_core #(.DATA_W(32), .PC_W(10), .NREGS(4)) u_dut32 (
    .clk(clk), .reset(reset), .bus(bus32.master),
    .pc(pc32), .retire(retire32), .halted(halted32));

  // 16-bit memory model with programmable wait states
  logic [15:0] imem16 [0:63];
  logic [15:0] dmem16 [0:63];
  int imem_wait16 = 0;
  int dmem_wait16 = 0;
  int icnt16, dcnt16;

  assign bus16.imem_valid = bus16.imem_req && (icnt16 >= imem_wait16);
  assign bus16.imem_rdata = imem16[bus16.imem_addr[5:0]];
  assign bus16.dmem_ready = bus16.dmem_req && (dcnt16 >= dmem_wait16);
  assign bus16.dmem_rdata = dmem16[bus16.dmem_addr[5:0]];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      icnt16 <= 0;
      dcnt16 <= 0;
    end else begin
      if (bus16.imem_req && bus16.imem_valid) icnt16 <= 0;
      else if (bus16.imem_req)                icnt16 <= icnt16 + 1;
      if (bus16.dmem_req && bus16.dmem_ready) dcnt16 <= 0;
      else if (bus16.dmem_req)                dcnt16 <= dcnt16 + 1;
    end
  end

  always @(posedge clk)
    if (bus16.dmem_req && bus16.dmem_ready && bus16.dmem_we)
      dmem16[bus16.dmem_addr[5:0]] <= bus16.dmem_wdata;

  logic [15:0] st16_addr [0:7];
  logic [15:0] st16_data [0:7];
  logic [9:0]  ftr16 [0:31];
  int st16_n, ret16_n, ftr_n;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      st16_n  <= 0;
      ret16_n <= 0;
      ftr_n   <= 0;
    end else begin
      if (bus16.dmem_req && bus16.dmem_ready && bus16.dmem_we) begin
        if (st16_n < 8) begin
          st16_addr[st16_n] <= bus16.dmem_addr;
          st16_data[st16_n] <= bus16.dmem_wdata;
        end
        st16_n <= st16_n + 1;
      end
      if (retire16) ret16_n <= ret16_n + 1;
      if (bus16.imem_req && bus16.imem_valid) begin
        if (ftr_n < 32) ftr16[ftr_n] <= bus16.imem_addr;
        ftr_n <= ftr_n + 1;
      end
    end
  end

  // 32-bit model: zero-wait fetch, one data wait state
  logic [15:0] imem32 [0:63];
  logic [31:0] dmem32 [0:63];
  logic [31:0] st32_addr [0:7];
  logic [31:0] st32_data [0:7];
  int dcnt32, st32_n;

  assign bus32.imem_valid = bus32.imem_req;
  assign bus32.imem_rdata = imem32[bus32.imem_addr[5:0]];
  assign bus32.dmem_ready = bus32.dmem_req && (dcnt32 >= 1);
  assign bus32.dmem_rdata = dmem32[bus32.dmem_addr[5:0]];

  always @(posedge clk)
    if (bus32.dmem_req && bus32.dmem_ready && bus32.dmem_we)
      dmem32[bus32.dmem_addr[5:0]] <= bus32.dmem_wdata;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt32 <= 0;
      st32_n <= 0;
    end else begin
      if (bus32.dmem_req && bus32.dmem_ready) dcnt32 <= 0;
      else if (bus32.dmem_req)                dcnt32 <= dcnt32 + 1;
      if (bus32.dmem_req && bus32.dmem_ready && bus32.dmem_we) begin
        if (st32_n < 8) begin
          st32_addr[st32_n] <= bus32.dmem_addr;
          st32_data[st32_n] <= bus32.dmem_wdata;
        end
        st32_n <= st32_n + 1;
      end
    end
  end

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [6:0] imm);
    return {op, ra, rb, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] ra, input logic [2:0] rb,
                                        input logic [2:0] rc);
    return {OP_ADD, ra, rb, 4'b0000, rc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_imem16();
    for (int i = 0; i < 64; i++) imem16[i] = enc_i(OP_HALT, 3'd0, 3'd0, 7'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_halt(input bit is32, input int bound, input string name);
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (is32 ? halted32 : halted16) break;
    end
    check(name, {63'd0, (is32 ? halted32 : halted16)}, 64'd1);
  endtask

  typedef struct {
    string       name;
    logic [6:0]  ia;
    logic [6:0]  ib;
    logic [15:0] instr;
    logic [2:0]  st_reg;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int idle_bad;
    logic [9:0] pc_snap;
    logic [9:0] exp_trace [0:11];

    vecs[0] = '{"add_wrap",   7'h7F, 7'd2,  enc_r(3'd3, 3'd1, 3'd2),               3'd3, 16'h0001};
    vecs[1] = '{"addi_pos",   7'd10, 7'd0,  enc_i(OP_ADDI, 3'd3, 3'd1, 7'd5),      3'd3, 16'h000F};
    vecs[2] = '{"subi_neg",   7'd1,  7'd0,  enc_i(OP_SUBI, 3'd3, 3'd1, 7'd3),      3'd3, 16'hFFFE};
    vecs[3] = '{"subi_min",   7'd63, 7'd0,  enc_i(OP_SUBI, 3'd3, 3'd1, 7'h40),     3'd3, 16'h007F};
    vecs[4] = '{"addi_min",   7'd0,  7'd0,  enc_i(OP_ADDI, 3'd3, 3'd1, 7'h40),     3'd3, 16'hFFC0};
    vecs[5] = '{"add_same",   7'd0,  7'd63, enc_r(3'd3, 3'd2, 3'd2),               3'd3, 16'h007E};
    vecs[6] = '{"r0_write",   7'd4,  7'd0,  enc_i(OP_ADDI, 3'd0, 3'd1, 7'd7),      3'd0, 16'h0000};
    vecs[7] = '{"add_r0",     7'd9,  7'd0,  enc_r(3'd3, 3'd1, 3'd0),               3'd3, 16'h0009};
    vecs[8] = '{"subi_wrap",  7'h40, 7'd0,  enc_i(OP_SUBI, 3'd3, 3'd1, 7'd63),     3'd3, 16'hFF81};
    vecs[9] = '{"addi_carry", 7'h7F, 7'd0,  enc_i(OP_ADDI, 3'd3, 3'd1, 7'd1),      3'd3, 16'h0000};

    for (int i = 0; i < 64; i++) imem32[i] = enc_i(OP_HALT, 3'd0, 3'd0, 7'd0);
    imem32[0] = enc_i(OP_ADDI, 3'd5, 3'd0, 7'h7F);   // r5 aliases r1
    imem32[1] = enc_i(OP_ADDI, 3'd2, 3'd0, 7'd2);
    imem32[2] = enc_r(3'd3, 3'd1, 3'd2);
    imem32[3] = enc_i(OP_SW, 3'd1, 3'd0, 7'd5);
    imem32[4] = enc_i(OP_SW, 3'd3, 3'd0, 7'd6);
    imem32[5] = enc_i(OP_SW, 3'd7, 3'd0, 7'd7);      // r7 aliases r3

    // Reset release and zero-wait first instruction timing
    clear_imem16();
    imem16[0] = enc_i(OP_ADDI, 3'd1, 3'd0, 7'd5);
    imem16[1] = enc_i(OP_SW, 3'd1, 3'd0, 7'd15);
    @(negedge clk);
    check("rst_imem_req", {63'd0, bus16.imem_req}, 64'd0);
    check("rst_pc", {54'd0, pc16}, 64'd0);
    reset = 1'b1;
    #1;
    check("first_req", {63'd0, bus16.imem_req}, 64'd1);
    check("first_addr", {54'd0, bus16.imem_addr}, 64'd0);
    @(negedge clk);
    check("decode_noretire", {63'd0, retire16}, 64'd0);
    @(negedge clk);
    check("exec_retire", {63'd0, retire16}, 64'd1);
    check("exec_pc", {54'd0, pc16}, 64'd0);
    @(negedge clk);
    check("fetch2_pc", {54'd0, pc16}, 64'd1);
    check("fetch2_noretire", {63'd0, retire16}, 64'd0);
    check("fetch2_retcnt", 64'(ret16_n), 64'd1);
    wait_halt(1'b0, 100, "first_halt");
    check("first_store", {48'd0, st16_data[0]}, 64'd5);

    // ALU vector table, varying fetch/data wait states
    for (int i = 0; i < 10; i++) begin
      clear_imem16();
      imem16[0] = enc_i(OP_ADDI, 3'd1, 3'd0, vecs[i].ia);
      imem16[1] = enc_i(OP_ADDI, 3'd2, 3'd0, vecs[i].ib);
      imem16[2] = vecs[i].instr;
      imem16[3] = enc_i(OP_SW, vecs[i].st_reg, 3'd0, 7'd10);
      imem_wait16 = i % 3;
      dmem_wait16 = i % 2;
      do_reset();
      wait_halt(1'b0, 300, {vecs[i].name, "_halt"});
      check({vecs[i].name, "_nst"}, 64'(st16_n), 64'd1);
      check({vecs[i].name, "_addr"}, {48'd0, st16_addr[0]}, 64'd10);
      check({vecs[i].name, "_data"}, {48'd0, st16_data[0]}, {48'd0, vecs[i].exp});
      check({vecs[i].name, "_ret"}, 64'(ret16_n), 64'd5);
      check({vecs[i].name, "_pc"}, {54'd0, pc16}, 64'd4);
    end
    imem_wait16 = 0;
    dmem_wait16 = 0;

    // Branches and JALR via fetch-address trace
    clear_imem16();
    imem16[0]  = enc_i(OP_ADDI, 3'd2, 3'd0, 7'd32);
    imem16[1]  = enc_i(OP_ADDI, 3'd1, 3'd0, 7'd1);
    imem16[2]  = enc_i(OP_BEQ,  3'd1, 3'd2, 7'd10);   // not taken
    imem16[3]  = enc_i(OP_BEQ,  3'd1, 3'd1, 7'd2);    // taken to 6
    imem16[6]  = enc_i(OP_JALR, 3'd5, 3'd2, 7'd0);    // r5 = 7, pc = 32
    imem16[32] = enc_i(OP_SW,   3'd5, 3'd0, 7'd11);
    imem16[33] = enc_i(OP_ADDI, 3'd6, 3'd6, 7'd1);
    imem16[34] = enc_i(OP_BEQ,  3'd6, 3'd1, 7'h7D);   // -3, back to 32 once
    exp_trace = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd6, 10'd32, 10'd33, 10'd34,
                  10'd32, 10'd33, 10'd34, 10'd35};
    do_reset();
    wait_halt(1'b0, 200, "br_halt");
    check("br_nfetch", 64'(ftr_n), 64'd12);
    for (int k = 0; k < 12; k++)
      check($sformatf("br_trace%0d", k), {54'd0, ftr16[k]}, {54'd0, exp_trace[k]});
    check("br_nst", 64'(st16_n), 64'd2);
    check("jalr_link", {48'd0, st16_data[0]}, 64'd7);
    check("br_pc", {54'd0, pc16}, 64'd35);

    // Store then load with two data wait states
    clear_imem16();
    imem16[0] = enc_i(OP_ADDI, 3'd1, 3'd0, 7'h79);    // -7
    imem16[1] = enc_i(OP_ADDI, 3'd2, 3'd0, 7'd20);
    imem16[2] = enc_i(OP_SW,   3'd1, 3'd2, 7'd3);
    imem16[3] = enc_i(OP_LW,   3'd4, 3'd2, 7'd3);
    imem16[4] = enc_i(OP_SW,   3'd4, 3'd0, 7'd12);
    dmem_wait16 = 2;
    do_reset();
    for (int c = 0; c < 50 && !bus16.dmem_req; c++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sw_req%0d", k), {63'd0, bus16.dmem_req}, 64'd1);
      check($sformatf("sw_we%0d", k), {63'd0, bus16.dmem_we}, 64'd1);
      check($sformatf("sw_addr%0d", k), {48'd0, bus16.dmem_addr}, 64'd23);
      check($sformatf("sw_wdata%0d", k), {48'd0, bus16.dmem_wdata}, 64'hFFF9);
      @(negedge clk);
    end
    check("sw_req_drop", {63'd0, bus16.dmem_req}, 64'd0);
    wait_halt(1'b0, 200, "mem_halt");
    check("mem_nst", 64'(st16_n), 64'd2);
    check("mem_st0_addr", {48'd0, st16_addr[0]}, 64'd23);
    check("lw_value", {48'd0, st16_data[1]}, 64'hFFF9);
    check("mem_ret", 64'(ret16_n), 64'd6);
    dmem_wait16 = 0;

    // Fetch withheld, then reset mid-wait
    clear_imem16();
    imem16[0] = enc_i(OP_ADDI, 3'd1, 3'd0, 7'd5);
    imem16[1] = enc_i(OP_ADDI, 3'd2, 3'd0, 7'd1);
    do_reset();
    @(negedge clk);
    @(negedge clk);
    imem_wait16 = 1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("wait_req%0d", k), {63'd0, bus16.imem_req}, 64'd1);
      check($sformatf("wait_addr%0d", k), {54'd0, bus16.imem_addr}, 64'd1);
      check($sformatf("wait_retire%0d", k), {63'd0, retire16}, 64'd0);
    end
    check("wait_retcnt", 64'(ret16_n), 64'd1);
    reset = 1'b0;
    #1;
    check("midrst_req", {63'd0, bus16.imem_req}, 64'd0);
    check("midrst_pc", {54'd0, pc16}, 64'd0);
    clear_imem16();
    imem16[0] = enc_i(OP_SW, 3'd1, 3'd0, 7'd14);
    imem_wait16 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_halt(1'b0, 100, "midrst_halt");
    check("midrst_r1_clear", {48'd0, st16_data[0]}, 64'd0);

    // HALT is terminal: no requests, pc frozen
    idle_bad = 0;
    pc_snap = pc16;
    repeat (20) begin
      @(negedge clk);
      if (bus16.imem_req || bus16.dmem_req || !halted16 || pc16 != pc_snap) idle_bad++;
    end
    check("halt_idle", 64'(idle_bad), 64'd0);

    // DATA_W=32, NREGS=4 instance (ran alongside since the last reset)
    wait_halt(1'b1, 200, "w32_halt");
    check("w32_nst", 64'(st32_n), 64'd3);
    check("w32_alias_wr", {32'd0, st32_data[0]}, 64'hFFFF_FFFF);
    check("w32_add_wrap", {32'd0, st32_data[1]}, 64'd1);
    check("w32_alias_rd", {32'd0, st32_data[2]}, 64'd1);
    check("w32_addr2", {32'd0, st32_addr[2]}, 64'd7);
    check("w32_pc", {54'd0, pc32}, 64'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
